// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MIPS32 execute stage and a word-wide handshaked bus.
// Optional MEM_RMW_EN: bus without byte enables; sub-word stores become read-modify-write.
module mem_access_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [1:0]  memDataSize_i,
  input  logic        memBitExt_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wrData_i,
  output logic [31:0] rdData_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        busReq_o,
  output logic        busWe_o,
  output logic [31:0] busAddr_o,
  output logic [31:0] busWData_o,
  output logic [3:0]  busBe_o,
  input  logic [31:0] busRData_i,
  input  logic        busAck_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
`ifdef MEM_RMW_EN
    S_RMW_RD,
    S_RMW_WR,
`endif
    S_DONE
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic        ext_q;
  logic [31:0] rd_data_q;
  logic        done_q;
  logic        fault_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
`ifdef MEM_RMW_EN
  logic [31:0] wdata_q;
`endif

  function automatic logic [31:0] lane_place(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    lane_place = d;
      2'd1:    lane_place = {2{d[15:0]}};
      default: lane_place = {4{d[7:0]}};
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    lane_mask = 4'hF;
      2'd1:    lane_mask = 4'b0011 << {lo[1], 1'b0};
      default: lane_mask = 4'b0001 << lo;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic ext,
                                               input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] s;
    s = d >> {lo, 3'b000};
    case (sz)
      2'd1:    load_extract = ext ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      2'd2:    load_extract = ext ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      default: load_extract = d;
    endcase
  endfunction

`ifdef MEM_RMW_EN
  function automatic logic [31:0] rmw_merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                            input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    return m;
  endfunction
`endif

  logic req;
  logic req_fault;
  assign req       = memRead_i | memWrite_i;
  assign req_fault = (memRead_i & memWrite_i) | (memDataSize_i == 2'd3)
                   | ((memDataSize_i == 2'd1) & addr_i[0])
                   | ((memDataSize_i == 2'd0) & (addr_i[1:0] != 2'b00));

  // The core must freeze in the request cycle itself, before any state has changed.
  assign stall_o = (state_q == S_IDLE) ? req : (state_q != S_DONE);

  // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      lo_q        <= '0;
      ext_q       <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
`ifdef MEM_RMW_EN
      wdata_q     <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            size_q <= memDataSize_i;
            lo_q   <= addr_i[1:0];
            ext_q  <= memBitExt_i;
            cnt_q  <= '0;
            if (req_fault) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              bus_req_q   <= 1'b1;
              bus_addr_q  <= {addr_i[31:2], 2'b00};
              bus_wdata_q <= lane_place(memDataSize_i, wrData_i);
`ifdef MEM_RMW_EN
              wdata_q  <= lane_place(memDataSize_i, wrData_i);
              bus_be_q <= 4'hF;
              if (memWrite_i && memDataSize_i != 2'd0) begin
                state_q  <= S_RMW_RD;
                bus_we_q <= 1'b0;
              end else begin
                state_q  <= S_ACCESS;
                bus_we_q <= memWrite_i;
              end
`else
              bus_be_q <= memWrite_i ? lane_mask(memDataSize_i, addr_i[1:0]) : 4'hF;
              bus_we_q <= memWrite_i;
              state_q  <= S_ACCESS;
`endif
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          if (busAck_i) begin
            cnt_q <= '0;
`ifdef MEM_RMW_EN
            if (state_q == S_RMW_RD) begin
              state_q     <= S_RMW_WR;
              bus_we_q    <= 1'b1;
              bus_wdata_q <= rmw_merge(busRData_i, wdata_q, lane_mask(size_q, lo_q));
            end else
`endif
            begin
              bus_req_q <= 1'b0;
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              if (!bus_we_q) rd_data_q <= load_extract(size_q, ext_q, lo_q, busRData_i);
            end
          end else if (cnt_q == TMO_LAST) begin
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            fault_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign rdData_o   = rd_data_q;
  assign done_o     = done_q;
  assign fault_o    = fault_q;
  assign busReq_o   = bus_req_q;
  assign busWe_o    = bus_we_q;
  assign busAddr_o  = bus_addr_q;
  assign busWData_o = bus_wdata_q;
  assign busBe_o    = bus_be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-lane reference model (ACK_TIMEOUT=4).
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0, memBitExt = 1'b0;
  logic [1:0]  memDataSize = '0;
  logic [31:0] addr = '0, wrData = '0, busRData = '0;
  logic        busAck = 1'b0;
  logic [31:0] rdData, busAddr, busWData;
  logic        stall, done, fault, busReq, busWe;
  logic [3:0]  busBe;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd  = '0;

  mem_access_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .memRead_i(memRead), .memWrite_i(memWrite),
    .memDataSize_i(memDataSize), .memBitExt_i(memBitExt), .addr_i(addr), .wrData_i(wrData),
    .rdData_o(rdData), .stall_o(stall), .done_o(done), .fault_o(fault), .busReq_o(busReq),
    .busWe_o(busWe), .busAddr_o(busAddr), .busWData_o(busWData), .busBe_o(busBe),
    .busRData_i(busRData), .busAck_i(busAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
  endfunction

  // Byte i of the bus word carries which byte of the store data.
  function automatic logic [31:0] m_repl(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (i >= int'(a)) && (i < int'(a) + nbytes(sz));
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit ext, input logic [1:0] a,
                                         input logic [31:0] d);
    int n = nbytes(sz);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(int'(a) + i) +: 8];
    if (!ext && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [1:0] sz, input logic [1:0] a,
                                          input logic [31:0] old_d, input logic [31:0] wd);
    logic [31:0] r = old_d;
    for (int i = 0; i < nbytes(sz); i++) r[8*(int'(a) + i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic run_txn(input bit rd, input bit wr, input logic [1:0] sz, input bit ext,
                         input logic [31:0] a, input logic [31:0] wd, input int w0, input int w1,
                         input logic [31:0] r0, input logic [31:0] r1);
    int w[2];
    logic [31:0] rdat[2], exp_wd[2];
    logic [3:0]  exp_be[2];
    bit          exp_we[2];
    bit          idle_fault, tmo, seen_done;
    int          nph, exp_stall, exp_reqs, stalls, reqs, ph, pw;
    w[0] = w0; w[1] = w1; rdat[0] = r0; rdat[1] = r1;
    idle_fault = (rd && wr) || sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd0 && a[1:0] != 2'b00);
`ifdef MEM_RMW_EN
    nph = idle_fault ? 0 : (wr && sz != 2'd0) ? 2 : 1;
    exp_be[0] = 4'hF; exp_be[1] = 4'hF;
    if (nph == 2) begin
      exp_we[0] = 1'b0; exp_we[1] = 1'b1;
      exp_wd[0] = '0;   exp_wd[1] = m_merge(sz, a[1:0], r0, wd);
    end else begin
      exp_we[0] = wr; exp_wd[0] = m_repl(sz, wd);
      exp_we[1] = 1'b0; exp_wd[1] = '0;
    end
`else
    nph = idle_fault ? 0 : 1;
    exp_we[0] = wr; exp_be[0] = wr ? m_be(sz, a[1:0]) : 4'hF; exp_wd[0] = m_repl(sz, wd);
    exp_we[1] = 1'b0; exp_be[1] = 4'hF; exp_wd[1] = '0;
`endif
    exp_stall = 1; exp_reqs = 0; tmo = 0;
    for (int p = 0; p < nph; p++) if (!tmo) begin
      if (w[p] >= TO) begin exp_stall += TO; exp_reqs += TO; tmo = 1; end
      else begin exp_stall += w[p] + 1; exp_reqs += w[p] + 1; end
    end
    if (tmo) exp_rd = '0;
    else if (rd && !idle_fault) exp_rd = m_load(sz, ext, a[1:0], r0);

    @(negedge clk);
    memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext; addr = a; wrData = wd;
    busAck = 1'b0;
    stalls = 0; reqs = 0; ph = 0; pw = 0; seen_done = 0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      #1;
      if (done) begin
        seen_done = 1;
        check("stall_cycles", stalls, exp_stall);
        check("req_cycles", reqs, exp_reqs);
        check("stall_in_done", stall, 0);
        check("busreq_in_done", busReq, 0);
        check("fault", fault, idle_fault || tmo);
        check("rddata", rdData, exp_rd);
        busAck = 1'($urandom_range(1));
      end else begin
        if (stall) stalls++;
        if (busReq) begin
          reqs++;
          if (ph < nph) begin
            check("bus_addr", busAddr, {a[31:2], 2'b00});
            check("bus_we", busWe, exp_we[ph]);
            check("bus_be", busBe, exp_be[ph]);
            if (exp_we[ph]) check("bus_wdata", busWData, exp_wd[ph]);
            if (pw == w[ph]) begin
              busAck = 1'b1; busRData = rdat[ph]; ph++; pw = 0;
            end else begin
              busAck = 1'b0; busRData = $urandom; pw++;
            end
          end else begin
            busAck = 1'b0;
          end
        end else begin
          busAck = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
      // Scramble the core-side inputs: the sequencer must work from latched copies.
      memRead = 1'b0; memWrite = 1'b0; memDataSize = 2'($urandom);
      memBitExt = 1'($urandom); addr = $urandom; wrData = $urandom;
    end
    if (!seen_done) check("done_reached", 0, 1);
    busAck = 1'b0;
    #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", stall, 0);
  endtask

  initial begin
    int  sel;
    bit  rd, wr;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rddata", rdData, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_busreq", busReq, 0);
    check("rst_buswe", busWe, 0);
    check("rst_busaddr", busAddr, 0);
    check("rst_buswdata", busWData, 0);
    check("rst_busbe", busBe, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1, 0, 2'd2, 0, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234, 32'h0);
    check("lb_value", rdData, 32'hFFFF_FF80);
    run_txn(1, 0, 2'd1, 1, 32'h0000_0102, 32'h0, 0, 0, 32'h8001_0000, 32'h0);
    check("lhu_value", rdData, 32'h0000_8001);
    run_txn(1, 0, 2'd1, 0, 32'h0000_0102, 32'h0, 1, 0, 32'h8001_0000, 32'h0);
    check("lh_value", rdData, 32'hFFFF_8001);
    run_txn(0, 1, 2'd2, 0, 32'h0000_0201, 32'h0000_00AB, 0, 0, 32'h1122_3344, 32'h0);
    run_txn(0, 1, 2'd1, 0, 32'h0000_0302, 32'h0000_BEEF, 2, 1, 32'hA5A5_A5A5, 32'h0);
    run_txn(0, 1, 2'd0, 0, 32'h0000_0400, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
    run_txn(1, 0, 2'd0, 0, 32'h0000_0102, 32'h0, 0, 0, 32'h0, 32'h0);
    run_txn(1, 0, 2'd3, 0, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);
    run_txn(1, 1, 2'd0, 0, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);
    run_txn(1, 0, 2'd1, 0, 32'h0000_0101, 32'h0, 0, 0, 32'h0, 32'h0);
    run_txn(1, 0, 2'd0, 0, 32'h0000_0500, 32'h0, 0, 0, 32'hCAFE_F00D, 32'h0);
    run_txn(1, 0, 2'd0, 0, 32'h0000_0500, 32'h0, 9, 0, 32'h1234_5678, 32'h0);
    check("timeout_rd_zero", rdData, 0);
    run_txn(1, 0, 2'd0, 0, 32'h0000_0504, 32'h0, 3, 0, 32'h1234_5678, 32'h0);
    check("ack_on_last", rdData, 32'h1234_5678);
    run_txn(0, 1, 2'd2, 0, 32'h0000_0603, 32'h0000_0077, 5, 0, 32'h0, 32'h0);
    run_txn(0, 1, 2'd1, 0, 32'h0000_0600, 32'h0000_1234, 0, 6, 32'h5555_5555, 32'h0);

    // Reset in the middle of a waiting bus phase.
    @(negedge clk);
    memRead = 1'b1; memWrite = 1'b0; memDataSize = 2'd0; addr = 32'h0000_0700; busAck = 1'b0;
    @(negedge clk);
    memRead = 1'b0;
    #1 check("pre_reset_busreq", busReq, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busreq", busReq, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    exp_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("no_done_after_rst", done | busReq, 0);
    end
    run_txn(1, 0, 2'd0, 0, 32'h0000_0800, 32'h0, 1, 0, 32'h0BAD_F00D, 32'h0);
    check("lw_after_rst", rdData, 32'h0BAD_F00D);

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(9));
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      run_txn(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom,
              ($urandom_range(7) == 0) ? 4 : int'($urandom_range(3)),
              ($urandom_range(7) == 0) ? 5 : int'($urandom_range(3)),
              $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
